// File: rtl/axil_bus_decoder.sv
// 1-to-NUM_M AXI4-Lite address decoder with registered downstream handshake and DECERR for unmapped windows.
// Optional error status outputs (err_count, err_addr) are enabled with `define ERR_STATUS_EN.
module axil_bus_decoder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int RESP_WIDTH  = 3,
  parameter int NUM_M       = 2,
  parameter int REGION_SIZE = 16
) (
  input  logic                               s0_axi_aclk,
  input  logic                               s0_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]              s0_axi_awaddr,
  input  logic                               s0_axi_awvalid,
  output logic                               s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]              s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]            s0_axi_wstrb,
  input  logic                               s0_axi_wvalid,
  output logic                               s0_axi_wready,
  output logic [RESP_WIDTH-1:0]              s0_axi_bresp,
  output logic                               s0_axi_bvalid,
  input  logic                               s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]              s0_axi_araddr,
  input  logic                               s0_axi_arvalid,
  output logic                               s0_axi_arready,
  output logic [DATA_WIDTH-1:0]              s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]              s0_axi_rresp,
  output logic                               s0_axi_rvalid,
  input  logic                               s0_axi_rready,
  output logic [NUM_M*ADDR_WIDTH-1:0]        m_axi_awaddr,
  output logic [NUM_M-1:0]                   m_axi_awvalid,
  input  logic [NUM_M-1:0]                   m_axi_awready,
  output logic [NUM_M*DATA_WIDTH-1:0]        m_axi_wdata,
  output logic [NUM_M*(DATA_WIDTH/8)-1:0]    m_axi_wstrb,
  output logic [NUM_M-1:0]                   m_axi_wvalid,
  input  logic [NUM_M-1:0]                   m_axi_wready,
  input  logic [NUM_M*RESP_WIDTH-1:0]        m_axi_bresp,
  input  logic [NUM_M-1:0]                   m_axi_bvalid,
  output logic [NUM_M-1:0]                   m_axi_bready,
  output logic [NUM_M*ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic [NUM_M-1:0]                   m_axi_arvalid,
  input  logic [NUM_M-1:0]                   m_axi_arready,
  input  logic [NUM_M*DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic [NUM_M*RESP_WIDTH-1:0]        m_axi_rresp,
  input  logic [NUM_M-1:0]                   m_axi_rvalid,
  output logic [NUM_M-1:0]                   m_axi_rready
`ifdef ERR_STATUS_EN
  ,
  output logic [15:0]                        err_count,
  output logic [ADDR_WIDTH-1:0]              err_addr
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int RB     = $clog2(REGION_SIZE);
  localparam int IDXW   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam logic [RESP_WIDTH-1:0] DECERR = RESP_WIDTH'(3);

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_BACK} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAIT, R_BACK} r_state_t;

  function automatic logic is_mapped(input logic [ADDR_WIDTH-1:0] a);
    return int'(a[ADDR_WIDTH-1:RB]) < NUM_M;
  endfunction

  function automatic logic [IDXW-1:0] port_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[RB +: IDXW];
  endfunction

  function automatic logic [NUM_M-1:0] port_sel(input logic [IDXW-1:0] i);
    logic [NUM_M-1:0] s;
    s    = '0;
    s[i] = 1'b1;
    return s;
  endfunction

  w_state_t              w_state_q, w_state_d;
  logic                  awready_q, awready_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [IDXW-1:0]       widx_q, widx_d;
  logic [NUM_M-1:0]      m_awvalid_q, m_awvalid_d;
  logic [NUM_M-1:0]      m_wvalid_q, m_wvalid_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d;
  logic                  w_decerr;

  r_state_t              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [IDXW-1:0]       ridx_q, ridx_d;
  logic [NUM_M-1:0]      m_arvalid_q, m_arvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0] rresp_q, rresp_d;
  logic                  r_decerr;

  // Write path: ready is a registered one-cycle pulse, so acceptance happens the cycle after both valids are seen.
  always_comb begin
    w_state_d   = w_state_q;
    awready_d   = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    widx_d      = widx_q;
    m_awvalid_d = m_awvalid_q;
    m_wvalid_d  = m_wvalid_q;
    bresp_d     = bresp_q;
    w_decerr    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = s0_axi_awvalid && s0_axi_wvalid && !awready_q;
        if (awready_q && s0_axi_awvalid && s0_axi_wvalid) begin
          waddr_d = s0_axi_awaddr;
          wdata_d = s0_axi_wdata;
          wstrb_d = s0_axi_wstrb;
          widx_d  = port_idx(s0_axi_awaddr);
          if (is_mapped(s0_axi_awaddr)) begin
            w_state_d   = W_FWD;
            m_awvalid_d = port_sel(port_idx(s0_axi_awaddr));
            m_wvalid_d  = port_sel(port_idx(s0_axi_awaddr));
          end else begin
            w_state_d = W_BACK;
            bresp_d   = DECERR;
            w_decerr  = 1'b1;
          end
        end
      end
      W_FWD: begin
        m_awvalid_d = m_awvalid_q & ~m_axi_awready;
        m_wvalid_d  = m_wvalid_q & ~m_axi_wready;
        if (!(|m_awvalid_d) && !(|m_wvalid_d)) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (m_axi_bvalid[widx_q]) begin
          bresp_d   = m_axi_bresp[widx_q*RESP_WIDTH +: RESP_WIDTH];
          w_state_d = W_BACK;
        end
      end
      W_BACK: if (s0_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d   = r_state_q;
    arready_d   = 1'b0;
    raddr_d     = raddr_q;
    ridx_d      = ridx_q;
    m_arvalid_d = m_arvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    r_decerr    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready_d = s0_axi_arvalid && !arready_q;
        if (arready_q && s0_axi_arvalid) begin
          raddr_d = s0_axi_araddr;
          ridx_d  = port_idx(s0_axi_araddr);
          if (is_mapped(s0_axi_araddr)) begin
            r_state_d   = R_FWD;
            m_arvalid_d = port_sel(port_idx(s0_axi_araddr));
          end else begin
            r_state_d = R_BACK;
            rdata_d   = '0;
            rresp_d   = DECERR;
            r_decerr  = 1'b1;
          end
        end
      end
      R_FWD: begin
        m_arvalid_d = m_arvalid_q & ~m_axi_arready;
        if (!(|m_arvalid_d)) r_state_d = R_WAIT;
      end
      R_WAIT: begin
        if (m_axi_rvalid[ridx_q]) begin
          rdata_d   = m_axi_rdata[ridx_q*DATA_WIDTH +: DATA_WIDTH];
          rresp_d   = m_axi_rresp[ridx_q*RESP_WIDTH +: RESP_WIDTH];
          r_state_d = R_BACK;
        end
      end
      R_BACK: if (s0_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s0_axi_aclk) begin
    if (!s0_axi_aresetn) begin
      w_state_q   <= W_IDLE;
      awready_q   <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      widx_q      <= '0;
      m_awvalid_q <= '0;
      m_wvalid_q  <= '0;
      bresp_q     <= '0;
      r_state_q   <= R_IDLE;
      arready_q   <= 1'b0;
      raddr_q     <= '0;
      ridx_q      <= '0;
      m_arvalid_q <= '0;
      rdata_q     <= '0;
      rresp_q     <= '0;
    end else begin
      w_state_q   <= w_state_d;
      awready_q   <= awready_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      widx_q      <= widx_d;
      m_awvalid_q <= m_awvalid_d;
      m_wvalid_q  <= m_wvalid_d;
      bresp_q     <= bresp_d;
      r_state_q   <= r_state_d;
      arready_q   <= arready_d;
      raddr_q     <= raddr_d;
      ridx_q      <= ridx_d;
      m_arvalid_q <= m_arvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
    end
  end

  // Handshake outputs are gated by reset so downstream valids fall as soon as reset is applied.
  logic run;
  assign run = s0_axi_aresetn;

  assign s0_axi_awready = awready_q & run;
  assign s0_axi_wready  = awready_q & run;
  assign s0_axi_bvalid  = (w_state_q == W_BACK) & run;
  assign s0_axi_bresp   = bresp_q;
  assign s0_axi_arready = arready_q & run;
  assign s0_axi_rvalid  = (r_state_q == R_BACK) & run;
  assign s0_axi_rdata   = rdata_q;
  assign s0_axi_rresp   = rresp_q;

  assign m_axi_awaddr  = {NUM_M{waddr_q}};
  assign m_axi_wdata   = {NUM_M{wdata_q}};
  assign m_axi_wstrb   = {NUM_M{wstrb_q}};
  assign m_axi_araddr  = {NUM_M{raddr_q}};
  assign m_axi_awvalid = m_awvalid_q & {NUM_M{run}};
  assign m_axi_wvalid  = m_wvalid_q & {NUM_M{run}};
  assign m_axi_arvalid = m_arvalid_q & {NUM_M{run}};
  assign m_axi_bready  = (run && w_state_q == W_RESP) ? port_sel(widx_q) : '0;
  assign m_axi_rready  = (run && r_state_q == R_WAIT) ? port_sel(ridx_q) : '0;

`ifdef ERR_STATUS_EN
  logic [15:0]           err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [16:0]           err_sum;

  // Both directions can decode-fail in the same cycle; the write address is recorded last so it wins.
  always_comb begin
    err_sum     = {1'b0, err_count_q} + 17'(w_decerr) + 17'(r_decerr);
    err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    err_addr_d  = err_addr_q;
    if (r_decerr) err_addr_d = s0_axi_araddr;
    if (w_decerr) err_addr_d = s0_axi_awaddr;
  end

  always_ff @(posedge s0_axi_aclk) begin
    if (!s0_axi_aresetn) begin
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
`endif

endmodule

// File: tb/tb_axil_bus_decoder.sv
// Scoreboard bench for axil_bus_decoder: directed transactions push expectations, negedge monitors pop and compare.
module tb_axil_bus_decoder;
  localparam int NM = 2, DW = 32, AW = 8, RW = 3, SW = DW / 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready, wready, bvalid, arready, rvalid;
  logic [RW-1:0] bresp, rresp;
  logic [DW-1:0] rdata;

  logic [NM*AW-1:0] m_awaddr, m_araddr;
  logic [NM*DW-1:0] m_wdata, m_rdata;
  logic [NM*SW-1:0] m_wstrb;
  logic [NM*RW-1:0] m_bresp, m_rresp;
  logic [NM-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [NM-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
`ifdef ERR_STATUS_EN
  logic [15:0] err_count;
  logic [AW-1:0] err_addr;
`endif

  axil_bus_decoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .NUM_M(NM), .REGION_SIZE(16)) dut (
    .s0_axi_aclk(clk), .s0_axi_aresetn(rstn),
    .s0_axi_awaddr(awaddr), .s0_axi_awvalid(awvalid), .s0_axi_awready(awready),
    .s0_axi_wdata(wdata), .s0_axi_wstrb(wstrb), .s0_axi_wvalid(wvalid), .s0_axi_wready(wready),
    .s0_axi_bresp(bresp), .s0_axi_bvalid(bvalid), .s0_axi_bready(bready),
    .s0_axi_araddr(araddr), .s0_axi_arvalid(arvalid), .s0_axi_arready(arready),
    .s0_axi_rdata(rdata), .s0_axi_rresp(rresp), .s0_axi_rvalid(rvalid), .s0_axi_rready(rready),
    .m_axi_awaddr(m_awaddr), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .m_axi_araddr(m_araddr), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
`ifdef ERR_STATUS_EN
    , .err_count(err_count), .err_addr(err_addr)
`endif
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected_event required=none", nm);
  endtask

  // Scoreboard queues
  typedef struct { int port; logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb; } dw_t;
  typedef struct { int port; logic [AW-1:0] addr; } dr_t;
  typedef struct { logic [DW-1:0] data; logic [RW-1:0] resp; } r_t;
  dw_t exp_dw[$];
  dr_t exp_dr[$];
  logic [RW-1:0] exp_b[$];
  r_t exp_r[$];

  // Downstream slave models: zero-wait aw/ar, optional wready stall, optional bvalid hold
  logic          bhold[NM];
  logic [RW-1:0] bresp_cfg[NM];
  logic [DW-1:0] rdata_cfg[NM];
  int            wstall_cfg[NM];
  int            wcyc[NM];
  logic [NM-1:0] aw_got, w_got;

  assign m_awready = '1;
  assign m_arready = '1;
  for (genvar g = 0; g < NM; g++) begin : g_wr
    assign m_wready[g] = (wcyc[g] >= wstall_cfg[g]);
  end

  always @(posedge clk) begin
    for (int p = 0; p < NM; p++) begin
      if (!rstn) begin
        aw_got[p] <= 1'b0; w_got[p] <= 1'b0; wcyc[p] <= 0;
        m_bvalid[p] <= 1'b0; m_rvalid[p] <= 1'b0;
        m_bresp[p*RW +: RW] <= '0; m_rresp[p*RW +: RW] <= '0; m_rdata[p*DW +: DW] <= '0;
      end else begin
        if (m_wvalid[p] && m_wready[p]) wcyc[p] <= 0;
        else if (m_wvalid[p]) wcyc[p] <= wcyc[p] + 1;
        if (m_awvalid[p] && m_awready[p]) aw_got[p] <= 1'b1;
        if (m_wvalid[p] && m_wready[p]) w_got[p] <= 1'b1;
        if (m_bvalid[p] && m_bready[p]) m_bvalid[p] <= 1'b0;
        if ((aw_got[p] || (m_awvalid[p] && m_awready[p])) && (w_got[p] || (m_wvalid[p] && m_wready[p]))
            && !m_bvalid[p] && !bhold[p]) begin
          m_bvalid[p] <= 1'b1;
          m_bresp[p*RW +: RW] <= bresp_cfg[p];
          aw_got[p] <= 1'b0;
          w_got[p] <= 1'b0;
        end
        if (m_rvalid[p] && m_rready[p]) m_rvalid[p] <= 1'b0;
        if (m_arvalid[p] && m_arready[p]) begin
          m_rvalid[p] <= 1'b1;
          m_rdata[p*DW +: DW] <= rdata_cfg[p];
          m_rresp[p*RW +: RW] <= '0;
        end
      end
    end
  end

  // Downstream monitor: write/read requests per port, plus wdata stability while stalled
  initial begin
    logic [AW-1:0] ma[NM];
    logic [DW-1:0] md[NM], pd[NM];
    logic [SW-1:0] ms[NM];
    logic ag[NM], wg[NM], stl[NM];
    dw_t e;
    dr_t er;
    for (int p = 0; p < NM; p++) begin ag[p] = 0; wg[p] = 0; stl[p] = 0; end
    forever begin
      @(negedge clk);
      for (int p = 0; p < NM; p++) begin
        if (!rstn) begin
          ag[p] = 0; wg[p] = 0; stl[p] = 0;
        end else begin
          if (stl[p] && m_wvalid[p]) chk("w_hold_data", m_wdata[p*DW +: DW], pd[p]);
          stl[p] = m_wvalid[p] && !m_wready[p];
          pd[p]  = m_wdata[p*DW +: DW];
          if (m_awvalid[p] && m_awready[p]) begin ag[p] = 1; ma[p] = m_awaddr[p*AW +: AW]; end
          if (m_wvalid[p] && m_wready[p]) begin
            wg[p] = 1; md[p] = m_wdata[p*DW +: DW]; ms[p] = m_wstrb[p*SW +: SW];
          end
          if (ag[p] && wg[p]) begin
            ag[p] = 0; wg[p] = 0;
            if (exp_dw.size() == 0) unexp("dw_unexpected");
            else begin
              e = exp_dw.pop_front();
              chk("dw_port", p, e.port);
              chk("dw_addr", ma[p], e.addr);
              chk("dw_data", md[p], e.data);
              chk("dw_strb", ms[p], e.strb);
            end
          end
          if (m_arvalid[p] && m_arready[p]) begin
            if (exp_dr.size() == 0) unexp("dr_unexpected");
            else begin
              er = exp_dr.pop_front();
              chk("dr_port", p, er.port);
              chk("dr_addr", m_araddr[p*AW +: AW], er.addr);
            end
          end
        end
      end
    end
  end

  // Upstream response monitor: B and R, with stability checks while the master stalls
  initial begin
    logic bstl, rstl;
    logic [RW-1:0] pb;
    r_t pr, er;
    bstl = 0; rstl = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        bstl = 0; rstl = 0;
      end else begin
        if (bvalid) begin
          if (bstl) chk("b_hold_resp", bresp, pb);
          if (bready) begin
            if (exp_b.size() == 0) unexp("b_unexpected");
            else chk("s0_bresp", bresp, exp_b.pop_front());
          end
        end
        bstl = bvalid && !bready; pb = bresp;
        if (rvalid) begin
          if (rstl) chk("r_hold", {rdata, rresp}, {pr.data, pr.resp});
          if (rready) begin
            if (exp_r.size() == 0) unexp("r_unexpected");
            else begin
              er = exp_r.pop_front();
              chk("s0_rdata", rdata, er.data);
              chk("s0_rresp", rresp, er.resp);
            end
          end
        end
        rstl = rvalid && !rready; pr.data = rdata; pr.resp = rresp;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic hs = 1'b0;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = awready && wready;
      tick();
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!hs) unexp("aw_timeout");
  endtask

  task automatic issue_read(input logic [AW-1:0] a);
    logic hs = 1'b0;
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = arready;
      tick();
      n++;
    end
    arvalid = 1'b0;
    if (!hs) unexp("ar_timeout");
  endtask

  task automatic take_b(input int delay);
    int n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (!bvalid) unexp("b_timeout");
    else begin
      repeat (delay) tick();
      bready = 1'b1;
      tick();
      bready = 1'b0;
    end
  endtask

  task automatic take_r(input int delay);
    int n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    if (!rvalid) unexp("r_timeout");
    else begin
      repeat (delay) tick();
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
  endtask

  function automatic logic [15:0] out_activity();
    return {awready, wready, bvalid, |bresp, arready, rvalid, |rdata, |rresp,
            |m_awvalid, |m_wvalid, |m_bready, |m_arvalid, |m_rready,
            |m_awaddr, |m_wdata | |m_wstrb, |m_araddr};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic hit;
    rstn = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    for (int p = 0; p < NM; p++) begin
      bhold[p] = 0; bresp_cfg[p] = '0; rdata_cfg[p] = '0; wstall_cfg[p] = 0;
    end
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outputs", out_activity(), 16'h0);
    tick();
    rstn = 1'b1;
    tick();

    // Mapped write to port 0
    exp_dw.push_back('{0, 8'h00, 32'd56, 4'hF});
    exp_b.push_back(3'd0);
    issue_write(8'h00, 32'd56, 4'hF);
    take_b(0);

    // Mapped write to port 1, awvalid-to-bvalid latency
    exp_dw.push_back('{1, 8'd20, 32'd37, 4'hF});
    exp_b.push_back(3'd0);
    lat = 0; hit = 0;
    fork
      issue_write(8'd20, 32'd37, 4'hF);
      while (!hit && lat < 20) begin
        @(negedge clk);
        if (bvalid) hit = 1;
        else begin tick(); lat++; end
      end
    join
    chk("latency_aw_to_b", lat, 4);
    tick();
    take_b(0);

    // awvalid alone must not be accepted; slave error response passes through
    awaddr = 8'd16; awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("aw_only_no_ready", {awready, wready}, 2'b00);
      tick();
    end
    bresp_cfg[1] = 3'd2;
    exp_dw.push_back('{1, 8'd16, 32'hCAFE0001, 4'hC});
    exp_b.push_back(3'd2);
    issue_write(8'd16, 32'hCAFE0001, 4'hC);
    take_b(0);
    bresp_cfg[1] = 3'd0;

    // Unmapped read, then unmapped write
    exp_r.push_back('{32'h0, 3'd3});
    issue_read(8'd40);
    take_r(0);
    exp_b.push_back(3'd3);
    issue_write(8'h80, 32'h12345678, 4'hF);
    take_b(0);
`ifdef ERR_STATUS_EN
    chk("err_count", err_count, 16'd2);
    chk("err_addr", err_addr, 8'h80);
`endif

    // Port 1 stalls wready, master stalls bready
    wstall_cfg[1] = 3;
    exp_dw.push_back('{1, 8'd24, 32'h0000A5A5, 4'h3});
    exp_b.push_back(3'd0);
    issue_write(8'd24, 32'h0000A5A5, 4'h3);
    for (int i = 0; i < 10 && m_wvalid[1]; i++) begin
      chk("no_b_before_w", bvalid, 1'b0);
      tick();
    end
    take_b(2);
    wstall_cfg[1] = 0;

    // Concurrent write to port 0 and read from port 1
    rdata_cfg[1] = 32'hDEADBEEF;
    exp_dw.push_back('{0, 8'd4, 32'h00001234, 4'hF});
    exp_b.push_back(3'd0);
    exp_dr.push_back('{1, 8'd24});
    exp_r.push_back('{32'hDEADBEEF, 3'd0});
    fork
      begin issue_write(8'd4, 32'h00001234, 4'hF); take_b(0); end
      begin issue_read(8'd24); take_r(1); end
    join

    // Mapped read from port 0
    rdata_cfg[0] = 32'h600DF00D;
    exp_dr.push_back('{0, 8'd8});
    exp_r.push_back('{32'h600DF00D, 3'd0});
    issue_read(8'd8);
    take_r(0);

    // Reset while waiting for the downstream response
    bhold[0] = 1'b1;
    exp_dw.push_back('{0, 8'h0C, 32'h11, 4'hF});
    issue_write(8'h0C, 32'h11, 4'hF);
    repeat (4) tick();
    chk("in_w_resp_bready", m_bready, 2'b01);
    rstn = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_reset_outputs", out_activity(), 16'h0);
    tick();
    rstn = 1'b1;
    bhold[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("no_b_after_reset", bvalid, 1'b0);
      tick();
    end
    exp_dw.push_back('{0, 8'h00, 32'h77, 4'hF});
    exp_b.push_back(3'd0);
    issue_write(8'h00, 32'h77, 4'hF);
    take_b(0);

    repeat (5) tick();
    chk("leftover_dw", exp_dw.size(), 0);
    chk("leftover_dr", exp_dr.size(), 0);
    chk("leftover_b", exp_b.size(), 0);
    chk("leftover_r", exp_r.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
